// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types used by the pipeline control blocks.
package cpu_types_pkg;

    // Architectural register index (32 GPRs, r0 hardwired to zero).
    typedef logic [4:0] regbits_t;

endpackage

// File: rtl/pipeline_ctrl_pkg.sv
// Types and helpers for the pipeline hazard sequencer.
package pipeline_ctrl_pkg;

    import cpu_types_pkg::regbits_t;

    // Sequencer states; encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } hazard_state_t;

    // Default number of MEM_WAIT cycles before the dcache watchdog trips.
    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    // True when the load in EX writes a register the decode instruction reads.
    // A load to r0 never creates a dependency.
    function automatic logic load_use_match(
        input regbits_t load_rt,
        input regbits_t dec_rs,
        input regbits_t dec_rt,
        input logic     dec_uses_rt
    );
        return (load_rt != '0) &&
               ((load_rt == dec_rs) || (dec_uses_rt && (load_rt == dec_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up on inc, hold at all-ones, clear to zero on clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central freeze/bubble sequencer for the five-stage pipeline.
// Priority: RST > halt > dcache wait > redirect > load-use > icache wait > advance.
// Control outputs are combinational; state, flags and counters are registered.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  regbits_t         Rs_IF_ID,
    input  regbits_t         Rt_IF_ID,
    input  logic             uses_rt_IF_ID,
    input  logic             dREN_ID_EX,
    input  regbits_t         Rt_ID_EX,
    input  logic             dREN_EX_MEM,
    input  logic             dWEN_EX_MEM,
    input  logic             redirect_EX,
    input  logic             halt_MEM_WB,
    output logic             pc_enable,
    output logic             enable_IF_ID,
    output logic             enable_ID_EX,
    output logic             enable_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             halt_out,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    hazard_state_t   state_q;
    hazard_state_t   next_state;
    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_inc;
    logic            mem_miss;
    logic            load_use;
    logic            redirect_taken;
    logic            stall_inc;

    assign mem_miss = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;
    assign load_use = dREN_ID_EX &
                      load_use_match(Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, uses_rt_IF_ID);
    assign wd_inc   = wd_q + WD_W'(1);
    assign state    = state_q;

    // Resolve the highest-priority hazard into enables, flushes and next state.
    always_comb begin
        pc_enable      = 1'b0;
        enable_IF_ID   = 1'b0;
        enable_ID_EX   = 1'b0;
        enable_EX_MEM  = 1'b0;
        enable_MEM_WB  = 1'b0;
        flush_IF_ID    = 1'b0;
        flush_ID_EX    = 1'b0;
        flush_EX_MEM   = 1'b0;
        redirect_taken = 1'b0;
        next_state     = state_q;
        if (RST) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            next_state   = RUN;
        end else if ((state_q == HALTED) || halt_MEM_WB) begin
            // Halt freezes everything; no bubbles are injected.
            next_state = HALTED;
        end else if (mem_miss) begin
            // Full freeze until the dcache answers; ihit/redirect wait too.
            next_state = MEM_WAIT;
        end else begin
            // dhit (or no memory op) lets the normal RUN rules apply this cycle.
            next_state    = RUN;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
            enable_ID_EX  = 1'b1;
            if (redirect_EX) begin
                // Fetch the target; squash the two wrong-path instructions.
                redirect_taken = 1'b1;
                pc_enable      = 1'b1;
                enable_IF_ID   = 1'b1;
                flush_IF_ID    = 1'b1;
                flush_ID_EX    = 1'b1;
            end else if (load_use) begin
                // Hold PC and decode, inject one bubble into EX.
                flush_ID_EX = 1'b1;
            end else if (!ihit) begin
                // No new instruction: bubble into decode, let older ones drain.
                enable_IF_ID = 1'b1;
                flush_IF_ID  = 1'b1;
            end else begin
                pc_enable    = 1'b1;
                enable_IF_ID = 1'b1;
            end
        end
    end

    assign stall_inc = ~RST & (state_q != HALTED) & ~pc_enable;

    // FSM state, sticky halt/timeout flags and the inline dcache watchdog.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            halt_out    <= 1'b0;
            mem_timeout <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q <= next_state;
            if (next_state == HALTED) begin
                halt_out <= 1'b1;
            end
            if (state_q == MEM_WAIT) begin
                if (wd_inc >= WD_LIMIT) begin
                    mem_timeout <= 1'b1;
                end
                if (next_state != MEM_WAIT) begin
                    wd_q <= '0;
                end else if (wd_q != WD_LIMIT) begin
                    wd_q <= wd_inc;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .inc   (stall_inc),
        .clr   (RST),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (CLK),
        .inc   (redirect_taken),
        .clr   (RST),
        .count (redirect_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

    localparam int T_OUT = 8;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic          ihit, dhit, uses_rt_IF_ID, dREN_ID_EX;
    logic          dREN_EX_MEM, dWEN_EX_MEM, redirect_EX, halt_MEM_WB;
    logic [4:0]    Rs_IF_ID, Rt_IF_ID, Rt_ID_EX;
    logic          pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
    logic          flush_IF_ID, flush_ID_EX, flush_EX_MEM, halt_out, mem_timeout;
    logic [1:0]    state;
    logic [CW-1:0] stall_cycles, redirect_count;

    pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(T_OUT), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID), .uses_rt_IF_ID(uses_rt_IF_ID),
        .dREN_ID_EX(dREN_ID_EX), .Rt_ID_EX(Rt_ID_EX),
        .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM),
        .redirect_EX(redirect_EX), .halt_MEM_WB(halt_MEM_WB),
        .pc_enable(pc_enable), .enable_IF_ID(enable_IF_ID), .enable_ID_EX(enable_ID_EX),
        .enable_EX_MEM(enable_EX_MEM), .enable_MEM_WB(enable_MEM_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
        .halt_out(halt_out), .mem_timeout(mem_timeout), .state(state),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Modes: 0 running, 1 waiting on dcache, 2 halted.
    int m_mode     = 0;
    int m_stall    = 0;
    int m_redir    = 0;
    int m_halt     = 0;
    int m_timeout  = 0;
    int m_wait_len = 0;

    // Expected controls packed as {pc, en IF_ID, ID_EX, EX_MEM, MEM_WB, fl IF_ID, ID_EX, EX_MEM}.
    logic [7:0] exp_ctrl;
    int         exp_redirect;
    int         exp_next_mode;

    task automatic model_eval();
        bit mem_busy, lu;
        mem_busy = (dREN_EX_MEM || dWEN_EX_MEM) && !dhit;
        lu = dREN_ID_EX && (Rt_ID_EX != 0) &&
             ((Rt_ID_EX == Rs_IF_ID) || (uses_rt_IF_ID && (Rt_ID_EX == Rt_IF_ID)));
        exp_redirect = 0;
        if (RST) begin
            exp_ctrl = 8'b0_0000_111; exp_next_mode = 0;
        end else if (m_mode == 2 || halt_MEM_WB) begin
            exp_ctrl = 8'b0_0000_000; exp_next_mode = 2;
        end else if (mem_busy) begin
            exp_ctrl = 8'b0_0000_000; exp_next_mode = 1;
        end else begin
            exp_next_mode = 0;
            if (redirect_EX) begin
                exp_ctrl = 8'b1_1111_110; exp_redirect = 1;
            end else if (lu) begin
                exp_ctrl = 8'b0_0111_010;
            end else if (!ihit) begin
                exp_ctrl = 8'b0_1111_100;
            end else begin
                exp_ctrl = 8'b1_1111_000;
            end
        end
    endtask

    task automatic model_advance();
        if (RST) begin
            m_mode = 0; m_stall = 0; m_redir = 0; m_halt = 0; m_timeout = 0; m_wait_len = 0;
        end else begin
            if (m_mode != 2 && !exp_ctrl[7] && m_stall < CMAX) m_stall++;
            if (exp_redirect == 1 && m_redir < CMAX) m_redir++;
            if (m_mode == 1) begin
                m_wait_len++;
                if (m_wait_len >= T_OUT) m_timeout = 1;
                if (exp_next_mode != 1) m_wait_len = 0;
            end
            if (exp_next_mode == 2) m_halt = 1;
            m_mode = exp_next_mode;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; uses_rt_IF_ID = 1'b0; dREN_ID_EX = 1'b0;
        dREN_EX_MEM = 1'b0; dWEN_EX_MEM = 1'b0; redirect_EX = 1'b0; halt_MEM_WB = 1'b0;
        Rs_IF_ID = 5'd0; Rt_IF_ID = 5'd0; Rt_ID_EX = 5'd0;
    endtask

    // Called just after a falling edge with inputs set; checks and crosses one rising edge.
    task automatic cycle();
        #1;
        model_eval();
        check("ctrl", {pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
                       flush_IF_ID, flush_ID_EX, flush_EX_MEM}, exp_ctrl);
        check("state", state, m_mode);
        check("halt_out", halt_out, m_halt);
        check("mem_timeout", mem_timeout, m_timeout);
        check("stall_cycles", stall_cycles, m_stall);
        check("redirect_count", redirect_count, m_redir);
        model_advance();
        @(negedge CLK);
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        RST = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        RST = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        @(negedge CLK);

        // Reset: flushes high, enables low, then clean advance.
        RST = 1'b1;
        #1;
        check("rst_flushes", {flush_IF_ID, flush_ID_EX, flush_EX_MEM}, 3'b111);
        check("rst_enables", {pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB}, 5'b0);
        do_reset(2);
        #1;
        check("post_rst_state", state, 0);
        check("post_rst_stall", stall_cycles, 0);
        check("post_rst_enables", {pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB}, 5'b11111);
        cycle();

        // Load-use: exactly one bubble, then r0 load gives no stall.
        dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5;
        cycle();
        check("lu_stall_count", stall_cycles, 1);
        Rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0;
        #1;
        check("lu_r0_pc", pc_enable, 1);
        cycle();

        // Redirect beats load-use and icache wait.
        do_reset(1);
        dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd7; Rt_IF_ID = 5'd7; uses_rt_IF_ID = 1'b1;
        ihit = 1'b0; redirect_EX = 1'b1;
        #1;
        check("redir_ctrl", {pc_enable, flush_IF_ID, flush_ID_EX}, 3'b111);
        cycle();
        check("redir_count", redirect_count, 1);

        // Dcache miss: four frozen cycles, dhit advances with no extra latency.
        do_reset(1);
        dREN_EX_MEM = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("miss_state", state, 1);
        dhit = 1'b1;
        #1;
        check("miss_dhit_pc", pc_enable, 1);
        cycle();
        idle_inputs();
        check("miss_exit_state", state, 0);
        check("miss_stall", stall_cycles, 4);
        check("miss_no_timeout", mem_timeout, 0);

        // Watchdog: long miss sets a sticky flag that only reset clears.
        do_reset(1);
        dREN_EX_MEM = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        dhit = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        check("wd_sticky", mem_timeout, 1);
        do_reset(1);
        check("wd_cleared", mem_timeout, 0);

        // Halt: frozen the same cycle, HALTED afterwards regardless of inputs.
        halt_MEM_WB = 1'b1;
        #1;
        check("halt_enables", {pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB}, 5'b0);
        cycle();
        halt_MEM_WB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ihit = 1'($urandom_range(0, 1)); redirect_EX = 1'($urandom_range(0, 1));
            cycle();
        end
        check("halt_state", state, 2);
        check("halt_out_set", halt_out, 1);

        // Counter saturation: a long icache wait overruns the counter width.
        do_reset(1);
        ihit = 1'b0;
        for (int i = 0; i < CMAX + 10; i++) cycle();
        check("stall_saturated", stall_cycles, CMAX);

        // Randomized traffic with occasional long misses, halts and resets.
        begin
            int miss_hold = 0;
            int halt_age  = 0;
            do_reset(1);
            for (int n = 0; n < 4000; n++) begin
                ihit          = ($urandom_range(0, 3) != 0);
                Rs_IF_ID      = 5'($urandom_range(0, 3));
                Rt_IF_ID      = 5'($urandom_range(0, 3));
                Rt_ID_EX      = 5'($urandom_range(0, 3));
                uses_rt_IF_ID = 1'($urandom_range(0, 1));
                dREN_ID_EX    = ($urandom_range(0, 2) == 0);
                redirect_EX   = ($urandom_range(0, 5) == 0);
                dREN_EX_MEM   = ($urandom_range(0, 3) == 0);
                dWEN_EX_MEM   = ($urandom_range(0, 5) == 0);
                dhit          = ($urandom_range(0, 2) != 0);
                halt_MEM_WB   = ($urandom_range(0, 299) == 0);
                if (miss_hold == 0 && $urandom_range(0, 79) == 0) miss_hold = $urandom_range(4, 14);
                if (miss_hold > 0) begin
                    dREN_EX_MEM = 1'b1; dhit = 1'b0; miss_hold--;
                end
                halt_age = (m_mode == 2) ? halt_age + 1 : 0;
                RST = ($urandom_range(0, 399) == 0) || (halt_age > 12);
                cycle();
            end
            RST = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
